voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic voice scheduler between the MIDI event decoder and the eight oscillator voice lanes. It accepts note-on and note-off events over a valid/ready handshake. It assigns each note to a voice slot by retrigger, free-slot or oldest-steal priority. It drives the per-voice on/note/velocity buses that select oscillator phase increments and velocity gain.

## Interface
Parameters:
- NUM_VOICES, 8, number of voice slots (≥2)
- NOTE_WIDTH, 7, MIDI note number width
- VEL_WIDTH, 3, velocity width (already quantised upstream)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- event_valid  in  1  event present
- event_ready  out  1  allocator can accept an event
- event_on  in  1  1 = note-on, 0 = note-off
- event_note  in  NOTE_WIDTH  note number
- event_vel  in  VEL_WIDTH  velocity
- all_off  in  1  synchronous panic: release every voice
- on_out  out  NUM_VOICES  per-voice gate
- note_out  out  NUM_VOICES*NOTE_WIDTH  per-voice note; voice i at [i*NOTE_WIDTH +: NOTE_WIDTH]
- velocity_out  out  NUM_VOICES*VEL_WIDTH  per-voice velocity, packed the same way
- stolen  out  1  one-cycle pulse when a note-on evicted an active voice

## Operation
- State per voice: on, note, vel, age. Age is a saturating counter of width clog2(NUM_VOICES)+1.
- FSM states: IDLE, SCAN, APPLY.
  - IDLE: event_ready=1. The event is latched on valid&&ready, scan index is set to 0, and the FSM goes to SCAN.
  - SCAN: one voice is examined per cycle, index 0..NUM_VOICES-1. The scan records:
    - first active voice whose note equals the event note (match);
    - lowest-index inactive voice (free);
    - oldest active voice: maximum age, ties broken by lowest index.
    - After the last index the FSM goes to APPLY.
  - APPLY: the result is committed and the FSM returns to IDLE.
- A note-on with event_vel==0 is treated as a note-off.
- Note-on target priority is match (retrigger), then free, then oldest (steal). On the target voice:
  - on=1, note=event_note, vel=event_vel, age=0;
  - every other active voice gets age+1, saturating;
  - stolen=1 for one cycle only for a steal.
- Note-off: every active voice whose note matches gets on=0 and age=0. Its note and vel are retained, so the oscillator keeps its pitch. No match means no state change.
- all_off is sampled in every state and has priority over everything else:
  - all on=0 and all ages=0; note and vel are retained;
  - any in-flight event is dropped and the FSM goes to IDLE.
  - If all_off and an accepting handshake coincide, the event is dropped.
- Voice state is modified only in APPLY or by all_off, so a scan always sees a consistent snapshot.

## Timing
- Reset values:
  - on_out=0, note_out=0, velocity_out=0, stolen=0;
  - all ages 0;
  - FSM=IDLE and event_ready=1 once rst deasserts.
- Assertion of rst takes effect immediately and asynchronously. Release of rst is synchronous to clk.
- Accept edge E0 is valid&&ready at a rising clk.
  - SCAN occupies edges E1..E(NUM_VOICES).
  - Outputs update at edge E(NUM_VOICES+1); this is 9 edges for NUM_VOICES=8.
  - stolen is high for exactly the cycle following that edge.
- event_ready is low from E0 until E(NUM_VOICES+1). The earliest next accept is E(NUM_VOICES+2), giving one event per NUM_VOICES+2 cycles.
- Upstream holds event fields stable while valid && !ready. Fields are not sampled after E0.
- all_off asserted at edge Ek clears on_out at Ek. event_ready is 1 after Ek.
- rst asserted mid-SCAN forces the reset values immediately. No partial commit ever appears.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then note-on 60 vel 5 → 9 edges later voice 0 shows on=1, note 60, vel 5. event_ready is low for exactly 9 cycles. stolen stays 0.
- Note-ons 60..67, all vel 3, fill voices 0..7, then note-on 70 vel 7 → voice 0 (oldest) becomes note 70 vel 7. stolen pulses for 1 cycle. Voices 1..7 are unchanged.
- With voices full, note-off 62 → voice 2 on=0 with note 62 retained. Then note-on 72 → voice 2 becomes note 72, stolen stays 0.
- Note-on 64 vel 2 while 64 is active on voice 4 → voice 4 vel=2 and age=0, no other voice changes. A following steal must not pick voice 4.
- Note-on 65 vel 0 → voice holding 65 is released. Note-off 99 (not active) → on_out unchanged.
- all_off at the 3rd SCAN cycle → on_out=0 at the next edge, the in-flight event never applies, and event_ready=1. Async rst mid-SCAN → all outputs are 0 before the next clk edge.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice scheduler.
//
// Accepts note-on / note-off events over a valid/ready handshake and assigns
// each note-on to a voice slot. The slot is chosen by retrigger (same note
// already sounding), then the lowest free slot, then the oldest active slot,
// which is stolen. Voices are scanned one per cycle. The result is committed
// in a single APPLY cycle, so the voice state never shows a partial update.
//
// Ports:
//   clk, rst      system clock; asynchronous active-high reset
//   event_valid   event present
//   event_ready   allocator can accept an event (high only in IDLE)
//   event_on      1 = note-on, 0 = note-off (a note-on with vel 0 is a note-off)
//   event_note    note number
//   event_vel     velocity
//   all_off       synchronous panic: release every voice, drop any event
//   on_out        per-voice gate
//   note_out      per-voice note, voice i at [i*NOTE_WIDTH +: NOTE_WIDTH]
//   velocity_out  per-voice velocity, packed the same way
//   stolen        one-cycle pulse when a note-on evicted an active voice
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned NOTE_WIDTH = 7,
    parameter int unsigned VEL_WIDTH  = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             event_valid,
    output logic                             event_ready,
    input  logic                             event_on,
    input  logic [NOTE_WIDTH-1:0]            event_note,
    input  logic [VEL_WIDTH-1:0]             event_vel,
    input  logic                             all_off,
    output logic [NUM_VOICES-1:0]            on_out,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0] note_out,
    output logic [NUM_VOICES*VEL_WIDTH-1:0]  velocity_out,
    output logic                             stolen
);

    localparam int unsigned IdxW = $clog2(NUM_VOICES);
    localparam int unsigned AgeW = $clog2(NUM_VOICES) + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_VOICES - 1);
    localparam logic [AgeW-1:0] AgeMax  = '1;

    typedef enum logic [1:0] {StIdle, StScan, StApply} state_e;

    state_e state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;

    // Latched event
    logic                  ev_on_q, ev_on_d;
    logic [NOTE_WIDTH-1:0] ev_note_q, ev_note_d;
    logic [VEL_WIDTH-1:0]  ev_vel_q, ev_vel_d;

    // Scan results
    logic            match_found_q, match_found_d;
    logic [IdxW-1:0] match_idx_q, match_idx_d;
    logic            free_found_q, free_found_d;
    logic [IdxW-1:0] free_idx_q, free_idx_d;
    logic            old_found_q, old_found_d;
    logic [IdxW-1:0] old_idx_q, old_idx_d;
    logic [AgeW-1:0] old_age_q, old_age_d;

    // Voice state
    logic [NUM_VOICES-1:0]                 on_q, on_d;
    logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] note_q, note_d;
    logic [NUM_VOICES-1:0][VEL_WIDTH-1:0]  vel_q, vel_d;
    logic [NUM_VOICES-1:0][AgeW-1:0]       age_q, age_d;
    logic                                  stolen_q, stolen_d;

    logic [IdxW-1:0] target;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ev_on_d       = ev_on_q;
        ev_note_d     = ev_note_q;
        ev_vel_d      = ev_vel_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        old_found_d   = old_found_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        on_d          = on_q;
        note_d        = note_q;
        vel_d         = vel_q;
        age_d         = age_q;
        stolen_d      = 1'b0;
        target        = '0;

        unique case (state_q)
            StIdle: begin
                if (event_valid) begin
                    ev_on_d       = event_on && (event_vel != '0);
                    ev_note_d     = event_note;
                    ev_vel_d      = event_vel;
                    idx_d         = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    old_found_d   = 1'b0;
                    state_d       = StScan;
                end
            end
            StScan: begin
                if (on_q[idx_q]) begin
                    if (!match_found_q && (note_q[idx_q] == ev_note_q)) begin
                        match_found_d = 1'b1;
                        match_idx_d   = idx_q;
                    end
                    // Strictly greater keeps the lowest index on an age tie.
                    if (!old_found_q || (age_q[idx_q] > old_age_q)) begin
                        old_found_d = 1'b1;
                        old_idx_d   = idx_q;
                        old_age_d   = age_q[idx_q];
                    end
                end else if (!free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                if (idx_q == LastIdx) begin
                    state_d = StApply;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StApply: begin
                if (ev_on_q) begin
                    // With no match and no free slot every voice is active, so
                    // the oldest-voice result is always valid here.
                    if (match_found_q) begin
                        target = match_idx_q;
                    end else if (free_found_q) begin
                        target = free_idx_q;
                    end else begin
                        target = old_idx_q;
                    end
                    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                        if (IdxW'(i) == target) begin
                            on_d[i]   = 1'b1;
                            note_d[i] = ev_note_q;
                            vel_d[i]  = ev_vel_q;
                            age_d[i]  = '0;
                        end else if (on_q[i] && (age_q[i] != AgeMax)) begin
                            age_d[i] = age_q[i] + AgeW'(1);
                        end
                    end
                    stolen_d = !match_found_q && !free_found_q;
                end else begin
                    // Note and velocity are kept so the oscillator holds pitch.
                    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                        if (on_q[i] && (note_q[i] == ev_note_q)) begin
                            on_d[i]  = 1'b0;
                            age_d[i] = '0;
                        end
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (all_off) begin
            on_d     = '0;
            age_d    = '0;
            stolen_d = 1'b0;
            state_d  = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            ev_vel_q      <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            old_found_q   <= 1'b0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            on_q          <= '0;
            note_q        <= '0;
            vel_q         <= '0;
            age_q         <= '0;
            stolen_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ev_on_q       <= ev_on_d;
            ev_note_q     <= ev_note_d;
            ev_vel_q      <= ev_vel_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            old_found_q   <= old_found_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            on_q          <= on_d;
            note_q        <= note_d;
            vel_q         <= vel_d;
            age_q         <= age_d;
            stolen_q      <= stolen_d;
        end
    end

    assign event_ready  = (state_q == StIdle);
    assign on_out       = on_q;
    assign note_out     = note_q;
    assign velocity_out = vel_q;
    assign stolen       = stolen_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator. Each event pushes the hand-derived
// voice image it should produce. A monitor pops and compares whenever
// event_ready rises, which is when the allocator has finished an event.
module tb_voice_allocator;

    localparam int NV = 8;
    localparam int NW = 7;
    localparam int VW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             event_valid;
    logic             event_ready;
    logic             event_on;
    logic [NW-1:0]    event_note;
    logic [VW-1:0]    event_vel;
    logic             all_off;
    logic [NV-1:0]    on_out;
    logic [NV*NW-1:0] note_out;
    logic [NV*VW-1:0] velocity_out;
    logic             stolen;

    voice_allocator #(
        .NUM_VOICES(NV),
        .NOTE_WIDTH(NW),
        .VEL_WIDTH (VW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_on    (event_on),
        .event_note  (event_note),
        .event_vel   (event_vel),
        .all_off     (all_off),
        .on_out      (on_out),
        .note_out    (note_out),
        .velocity_out(velocity_out),
        .stolen      (stolen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NV-1:0]    on;
        logic [NV*NW-1:0] note;
        logic [NV*VW-1:0] vel;
        logic             stl;
        string            name;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [NV-1:0]    exp_on;
    logic [NV*NW-1:0] exp_note;
    logic [NV*VW-1:0] exp_vel;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_voice(input int v, input int n, input int vel);
        exp_on[v]           = 1'b1;
        exp_note[v*NW +: NW] = NW'(n);
        exp_vel[v*VW +: VW]  = VW'(vel);
    endtask

    task automatic release_voice(input int v);
        exp_on[v] = 1'b0;
    endtask

    task automatic push(input string name, input logic stl);
        exp_t e;
        e.on   = exp_on;
        e.note = exp_note;
        e.vel  = exp_vel;
        e.stl  = stl;
        e.name = name;
        sb.push_back(e);
    endtask

    // Drive one event, then count cycles with event_ready low (bounded).
    task automatic issue(input logic on, input int n, input int vel);
        int cnt;
        @(negedge clk);
        event_valid = 1'b1;
        event_on    = on;
        event_note  = NW'(n);
        event_vel   = VW'(vel);
        @(posedge clk);
        #1;
        event_valid = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (event_ready || cnt >= 40) break;
            cnt++;
        end
        check("ready_low_cycles", 64'(cnt), 64'd9);
    endtask

    // Monitor
    logic prev_ready = 1'b1;
    logic pend_clear = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (pend_clear) begin
            check("stolen_one_cycle", 64'(stolen), 64'd0);
            pend_clear = 1'b0;
        end
        if (event_ready && !prev_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got on=%0h expected no output", on_out);
            end else begin
                e = sb.pop_front();
                check({e.name, "_on"}, 64'(on_out), 64'(e.on));
                check({e.name, "_note"}, 64'(note_out), 64'(e.note));
                check({e.name, "_vel"}, 64'(velocity_out), 64'(e.vel));
                check({e.name, "_stolen"}, 64'(stolen), 64'(e.stl));
                pend_clear = 1'b1;
            end
        end
        prev_ready = event_ready;
    end

    initial begin
        rst         = 1'b1;
        event_valid = 1'b0;
        event_on    = 1'b0;
        event_note  = '0;
        event_vel   = '0;
        all_off     = 1'b0;
        exp_on      = '0;
        exp_note    = '0;
        exp_vel     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_on", 64'(on_out), 64'd0);
        check("reset_note", 64'(note_out), 64'd0);
        check("reset_vel", 64'(velocity_out), 64'd0);
        check("reset_stolen", 64'(stolen), 64'd0);
        check("reset_ready", 64'(event_ready), 64'd1);

        // First note lands on voice 0
        set_voice(0, 60, 5);
        push("first_on60", 1'b0);
        issue(1'b1, 60, 5);

        // Same note retriggers voice 0, then 61..67 fill voices 1..7
        set_voice(0, 60, 3);
        push("retrig60", 1'b0);
        issue(1'b1, 60, 3);
        for (int n = 61; n <= 67; n++) begin
            set_voice(n - 60, n, 3);
            push("fill", 1'b0);
            issue(1'b1, n, 3);
        end

        // Full: voice 0 is oldest (age 7) and gets stolen
        set_voice(0, 70, 7);
        push("steal70", 1'b1);
        issue(1'b1, 70, 7);

        // Note-off 62 releases voice 2, note retained
        release_voice(2);
        push("off62", 1'b0);
        issue(1'b0, 62, 3);

        // Free voice 2 is reused, no steal
        set_voice(2, 72, 4);
        push("free72", 1'b0);
        issue(1'b1, 72, 4);

        // Retrigger 64 on voice 4 with new velocity
        set_voice(4, 64, 2);
        push("retrig64", 1'b0);
        issue(1'b1, 64, 2);

        // Ages now v0=2 v1=9 v2=1 v3=7 v4=0 v5=5 v6=4 v7=3: voice 1 is stolen
        set_voice(1, 80, 6);
        push("steal80", 1'b1);
        issue(1'b1, 80, 6);

        // Velocity-0 note-on releases voice 5
        release_voice(5);
        push("vel0_off65", 1'b0);
        issue(1'b1, 65, 0);

        // Note-off of an inactive note changes nothing
        push("off99", 1'b0);
        issue(1'b0, 99, 0);

        // all_off during the third scan cycle
        @(negedge clk);
        event_valid = 1'b1;
        event_on    = 1'b1;
        event_note  = 7'd90;
        event_vel   = 3'd7;
        @(posedge clk);
        #1;
        event_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        all_off = 1'b1;
        exp_on  = '0;
        push("all_off", 1'b0);
        @(posedge clk);
        #1;
        all_off = 1'b0;
        check("all_off_on_now", 64'(on_out), 64'd0);
        check("all_off_ready", 64'(event_ready), 64'd1);
        repeat (12) @(negedge clk);
        check("all_off_no_late_apply", 64'(on_out), 64'd0);

        // After panic all voices are free: lowest slot wins
        set_voice(0, 91, 1);
        push("after_panic91", 1'b0);
        issue(1'b1, 91, 1);

        // Asynchronous reset mid-scan
        @(negedge clk);
        event_valid = 1'b1;
        event_on    = 1'b1;
        event_note  = 7'd92;
        event_vel   = 3'd2;
        @(posedge clk);
        #1;
        event_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst      = 1'b1;
        exp_on   = '0;
        exp_note = '0;
        exp_vel  = '0;
        push("rst_mid_scan", 1'b0);
        #1;
        check("rst_async_on", 64'(on_out), 64'd0);
        check("rst_async_note", 64'(note_out), 64'd0);
        check("rst_async_vel", 64'(velocity_out), 64'd0);
        check("rst_async_ready", 64'(event_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_no_late_apply", 64'(on_out), 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
